f_pc_seq: RTL and testbench
===========================

# f_pc_seq

Next-PC sequencer for the fetch stage. Each cycle it decides what the PC register loads and whether it holds. It arbitrates between four sources: sequential fetch, branch/jump redirects from D, exception entry and ERET return. A branch redirect that arrives while fetch is stalled is buffered and applied on the first unstalled cycle. The block drives the PC register's `npc` and `stall` inputs directly.

## Interface
- `PC_BIAS`, 32'h0000_3000, reset/boot PC.
- `EXC_ENTRY`, 32'h0000_4180, exception handler entry address.
- `clk`  in  1  system clock, all state updates on posedge.
- `rst`  in  1  asynchronous, active-high reset.
- `pc`  in  32  current fetch PC (PC register output).
- `stall_in`  in  1  hazard-unit stall request for F.
- `br_req`  in  1  one-cycle pulse: D-stage branch/jump taken.
- `br_target`  in  32  redirect target, valid with `br_req`.
- `exc_req`  in  1  exception/interrupt commit from M.
- `eret_req`  in  1  ERET commit.
- `epc`  in  32  return address from CP0, valid with `eret_req`.
- `npc`  out  32  value the PC register loads on the next edge.
- `pc_stall`  out  1  PC register hold enable.
- `pend`  out  1  a buffered redirect is held (debug/hazard visibility).

## Operation
- States: `RUN` (no buffered redirect) and `HOLD` (buffered target in `pend_tgt`). `pend` = (state == `HOLD`).
- `pc_stall` = `stall_in` & ~`exc_req` & ~`eret_req`. Exception entry and ERET are never stalled.
- `npc` priority, combinational:
  1. `exc_req` → `EXC_ENTRY`.
  2. `eret_req` → `epc`.
  3. `HOLD` & ~`stall_in` → `pend_tgt`.
  4. `br_req` → `br_target`.
  5. Otherwise `pc` + 4, modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- `npc` is also driven while `pc_stall`=1; the PC register ignores it in that case.
- Transitions on posedge:
  - `exc_req` or `eret_req` → `RUN`. Any buffered or incoming `br_req` is discarded.
  - `RUN`, `br_req` & `stall_in` → `HOLD`, `pend_tgt` ← `br_target`.
  - `RUN`, `br_req` & ~`stall_in` → stay `RUN`. The redirect is applied directly.
  - `HOLD`, `stall_in`, `br_req` → stay `HOLD`, `pend_tgt` ← `br_target` (newest wins).
  - `HOLD`, ~`stall_in`, ~`br_req` → `RUN`. `pend_tgt` was applied this cycle.
  - `HOLD`, ~`stall_in`, `br_req` → stay `HOLD`. The old `pend_tgt` is applied this cycle, and `pend_tgt` ← `br_target`. This gives in-order, depth-1 buffering.
- `exc_req` and `eret_req` both high: exception wins, and `npc` = `EXC_ENTRY`.

## Timing
- `npc` and `pc_stall` are combinational from inputs and state, with zero latency. The PC register reflects them on the same edge.
- A buffered redirect is applied on the first cycle with `stall_in`=0. The PC holds `pend_tgt` one edge later.
- Reset is asynchronous. While `rst`=1: state = `RUN`, `pend_tgt` = 0, `pend` = 0, `npc` = `PC_BIAS`, `pc_stall` = 0.
- Reset asserted mid-`HOLD` drops the buffered redirect immediately, without waiting for a clock edge.
- The first posedge after `rst` deasserts performs a normal evaluation.

## Configuration
- Macro: `PCSEQ_ALIGN_CHK_EN`.
- When defined, the block adds output `fetch_adel` (1 bit). It is combinational and is 1 when `pc`[1:0] != 0 or `pc` is outside [`PC_BIAS`, 32'h0000_6FFC]. It is 0 during reset.
- `fetch_adel` does not alter `npc`. Exception entry is still requested through `exc_req` by the pipeline.
- When undefined, the port and its logic are absent, and all other behaviour is identical.

## Test plan
- Reset then free-run: `rst` pulse asynchronous to `clk` → `npc`=0x3000 during reset; with `pc` following `npc`, 0x3000, 0x3004 and 0x3008 appear on consecutive edges; `pend`=0.
- Stalled branch: `pc`=0x3010, `stall_in`=1 for 3 cycles, `br_req` pulse with target 0x3100 in cycle 1 → `pend`=1 for cycles 2-4; cycle after stall drops `npc`=0x3100 and `pend`=0 next edge.
- Exception overrides stall and buffered branch: in `HOLD` with `stall_in`=1, `exc_req`=1 → `pc_stall`=0, `npc`=0x4180, next state `RUN`, `pend`=0.
- ERET vs exception same cycle: `exc_req`=`eret_req`=1, `epc`=0x3040 → `npc`=0x4180. Then `eret_req` alone → `npc`=0x3040.
- Back-to-back buffering: `HOLD` with `pend_tgt`=0x3200 and `stall_in`=0, plus `br_req` to 0x3300 → `npc`=0x3200 and `pend` stays 1. Next unstalled cycle → `npc`=0x3300 and `pend`→0.
- With `PCSEQ_ALIGN_CHK_EN`: `pc`=0x3002 → `fetch_adel`=1; `pc`=0x7000 → 1; `pc`=0x6FFC → 0. Without the macro, compile succeeds and the port is absent.

Source files
------------

// File: rtl/f_pc_seq.sv
// Next-PC sequencer for fetch: arbitrates sequential fetch, branch redirects,
// exception entry and ERET. Optional fetch address check under PCSEQ_ALIGN_CHK_EN.
module f_pc_seq #(
  parameter logic [31:0] PC_BIAS   = 32'h0000_3000,
  parameter logic [31:0] EXC_ENTRY = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        stall_in,
  input  logic        br_req,
  input  logic [31:0] br_target,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  output logic [31:0] npc,
  output logic        pc_stall,
  output logic        pend
`ifdef PCSEQ_ALIGN_CHK_EN
  ,
  output logic        fetch_adel
`endif
);

  localparam int unsigned AW = 32;
  localparam logic [AW-1:0] PC_LIMIT = 32'h0000_6FFC;

  typedef enum logic {RUN, HOLD} state_t;

  state_t        state;
  logic [AW-1:0] pend_tgt;
  logic          redirect;

  assign redirect = exc_req | eret_req;

  // Depth-1 redirect buffer; exception/ERET flush anything pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      pend_tgt <= '0;
    end else if (redirect) begin
      state    <= RUN;
    end else begin
      case (state)
        RUN: begin
          if (br_req && stall_in) begin
            state    <= HOLD;
            pend_tgt <= br_target;
          end
        end
        HOLD: begin
          if (br_req) begin
            pend_tgt <= br_target;
          end else if (!stall_in) begin
            state    <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  assign pend = (state == HOLD);

  // Next-PC priority: exception > ERET > buffered redirect > branch > pc+4.
  always_comb begin
    npc      = pc + AW'(4);
    pc_stall = 1'b0;
    if (rst) begin
      npc = PC_BIAS;
    end else begin
      pc_stall = stall_in & ~exc_req & ~eret_req;
      if (exc_req)                        npc = EXC_ENTRY;
      else if (eret_req)                  npc = epc;
      else if (state == HOLD && !stall_in) npc = pend_tgt;
      else if (br_req)                    npc = br_target;
    end
  end

`ifdef PCSEQ_ALIGN_CHK_EN
  always_comb begin
    fetch_adel = 1'b0;
    if (!rst) begin
      fetch_adel = (pc[1:0] != 2'b00) || (pc < PC_BIAS) || (pc > PC_LIMIT);
    end
  end
`endif

endmodule

// File: tb/tb_f_pc_seq.sv
// Scoreboard bench for f_pc_seq: queue-based reference model, directed
// scenarios followed by randomized traffic.
module tb_f_pc_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        stall_in;
  logic        br_req;
  logic [31:0] br_target;
  logic        exc_req;
  logic        eret_req;
  logic [31:0] epc;
  logic [31:0] npc;
  logic        pc_stall;
  logic        pend;
`ifdef PCSEQ_ALIGN_CHK_EN
  logic        fetch_adel;
`endif

  f_pc_seq dut (
    .clk(clk), .rst(rst), .pc(pc), .stall_in(stall_in), .br_req(br_req),
    .br_target(br_target), .exc_req(exc_req), .eret_req(eret_req), .epc(epc),
    .npc(npc), .pc_stall(pc_stall), .pend(pend)
`ifdef PCSEQ_ALIGN_CHK_EN
    , .fetch_adel(fetch_adel)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] npc;
    logic        stall;
    logic        pend;
    logic        adel;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] pq[$];      // buffered redirects (reference model, depth <= 1)
  logic [31:0] pc_next;    // bench-side PC register
  int          checks = 0;
  int          errors = 0;
  event        sample_ev;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expectation per presented cycle.
  initial begin
    exp_t e;
    forever begin
      @(sample_ev);
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("npc", npc, e.npc);
        chk("pc_stall", {31'd0, pc_stall}, {31'd0, e.stall});
        chk("pend", {31'd0, pend}, {31'd0, e.pend});
`ifdef PCSEQ_ALIGN_CHK_EN
        chk("fetch_adel", {31'd0, fetch_adel}, {31'd0, e.adel});
`endif
      end
    end
  end

  // One cycle: drive at negedge, predict, push, hand to monitor.
  task automatic cyc(input logic s, input logic b, input logic [31:0] t,
                     input logic x, input logic r, input logic [31:0] e);
    exp_t ex;
    int   had;
    @(negedge clk);
    pc = pc_next; stall_in = s; br_req = b; br_target = t;
    exc_req = x; eret_req = r; epc = e;
    #1;
    had      = pq.size();
    ex.pend  = (had != 0);
    ex.stall = s && !x && !r;
    if (x)               ex.npc = 32'h0000_4180;
    else if (r)          ex.npc = e;
    else if (had && !s)  ex.npc = pq[0];
    else if (b)          ex.npc = t;
    else                 ex.npc = pc + 32'd4;
    ex.adel = (pc[1:0] != 0) || (pc < 32'h3000) || (pc > 32'h6FFC);
    sb.push_back(ex);
    ->sample_ev;
    if (x || r) begin
      pq.delete();
    end else begin
      if (had && !s) void'(pq.pop_front());
      if (b && (s || had)) begin
        pq.delete();
        pq.push_back(t);
      end
    end
    if (!ex.stall) pc_next = ex.npc;
  endtask

  task automatic idle(input logic s);
    cyc(s, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_npc", npc, 32'h0000_3000);
    chk("rst_stall", {31'd0, pc_stall}, 32'd0);
    chk("rst_pend", {31'd0, pend}, 32'd0);
    stall_in = 1'b0; br_req = 1'b0; exc_req = 1'b0; eret_req = 1'b0;
    @(posedge clk);
    #3 rst = 1'b0;
    pq.delete();
    pc_next = 32'h0000_3000;
  endtask

  function automatic logic [31:0] rnd_tgt();
    if ($urandom_range(0, 9) == 0) return $urandom();
    return 32'h3000 + {18'd0, 12'($urandom_range(0, 4095)), 2'b00};
  endfunction

  initial begin
    rst = 1'b0; pc = 32'h3000; stall_in = 0; br_req = 0; br_target = 0;
    exc_req = 0; eret_req = 0; epc = 0; pc_next = 32'h3000;
    #7;
    do_reset();

    // Free run from boot PC.
    idle(1'b0);
    chk("boot_pc0", pc, 32'h3000);
    idle(1'b0);
    chk("boot_pc1", pc, 32'h3004);
    idle(1'b0);
    chk("boot_pc2", pc, 32'h3008);

    // Stalled branch buffered until stall drops.
    pc_next = 32'h3010;
    cyc(1, 1, 32'h3100, 0, 0, 0);
    idle(1'b1);
    chk("hold_pend", {31'd0, pend}, 32'd1);
    idle(1'b1);
    idle(1'b0);
    chk("hold_apply", npc, 32'h3100);
    idle(1'b0);
    chk("hold_clear", {31'd0, pend}, 32'd0);

    // Exception overrides stall and the buffered branch.
    cyc(1, 1, 32'h3500, 0, 0, 0);
    cyc(1, 0, 32'h0, 1, 0, 0);
    chk("exc_stall", {31'd0, pc_stall}, 32'd0);
    chk("exc_npc", npc, 32'h4180);
    idle(1'b0);
    chk("exc_flush", {31'd0, pend}, 32'd0);

    // Exception beats ERET, then ERET alone.
    cyc(0, 0, 32'h0, 1, 1, 32'h3040);
    chk("exc_vs_eret", npc, 32'h4180);
    cyc(0, 0, 32'h0, 0, 1, 32'h3040);
    chk("eret_npc", npc, 32'h3040);

    // Back-to-back buffering keeps order.
    cyc(1, 1, 32'h3200, 0, 0, 0);
    cyc(0, 1, 32'h3300, 0, 0, 0);
    chk("b2b_first", npc, 32'h3200);
    idle(1'b0);
    chk("b2b_second", npc, 32'h3300);
    chk("b2b_still_pend", {31'd0, pend}, 32'd1);
    idle(1'b0);
    chk("b2b_drained", {31'd0, pend}, 32'd0);

    // Reset in HOLD drops the buffer without a clock edge.
    cyc(1, 1, 32'h3600, 0, 0, 0);
    idle(1'b1);
    do_reset();
    idle(1'b0);

`ifdef PCSEQ_ALIGN_CHK_EN
    pc_next = 32'h3002; idle(1'b1);
    chk("adel_misalign", {31'd0, fetch_adel}, 32'd1);
    pc_next = 32'h7000; idle(1'b1);
    chk("adel_high", {31'd0, fetch_adel}, 32'd1);
    pc_next = 32'h6FFC; idle(1'b1);
    chk("adel_edge_ok", {31'd0, fetch_adel}, 32'd0);
    pc_next = 32'h3000;
`endif

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      logic x;
      logic r;
      x = ($urandom_range(0, 19) == 0);
      r = ($urandom_range(0, 19) == 0);
      cyc($urandom_range(0, 9) < 4, $urandom_range(0, 3) == 0, rnd_tgt(), x, r, rnd_tgt());
    end

    @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
